apb_uart: RTL and testbench



---
 rtl/apb_uart.sv | 233 +++++++++++++++++++++++
 tb/tb_apb_uart.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart.sv
// rtl/apb_uart.sv - APB-mapped UART with a fixed 16-clock bit time, optional parity and a two-flop rxd synchronizer.
// CTRL at word 0 and STATUS at word 1; TX and RX engines run independently.
module apb_uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] padd,
  input  logic [31:0] pdata,
  input  logic        psel,
  input  logic        pen,
  input  logic        pwr,
  input  logic [3:0]  PSTRB,
  output logic [31:0] prdata,
  output logic        txd,
  input  logic        rxd
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

  logic [7:0] txdata_q, txdata_d;
  logic       txstart_q, txstart_d;
  logic       paren_q, paren_d;
  logic       parodd_q, parodd_d;
  logic       rxen_q, rxen_d;

  state_e     tx_state_q;
  logic [3:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_sh_q;
  logic       tx_par_q;
  logic       tx_paren_q;
  logic       txd_q;

  state_e     rx_state_q;
  logic [3:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q;
  logic       rx_paren_q;
  logic       rx_parodd_q;
  logic       rx_parbit_q;
  logic       sync1_q, sync2_q, rx_prev_q;
  logic [7:0] rxdata_q;
  logic       rxvalid_q, parerr_q, frmerr_q;

  logic wr_ctrl;
  logic tx_launch;
  logic txbusy;
  logic rx_fall;
  logic unused_wr_bits;

  assign wr_ctrl   = psel & pen & pwr & (padd == 32'd0);
  assign tx_launch = (tx_state_q == ST_IDLE) & txstart_q;
  assign txbusy    = (tx_state_q != ST_IDLE);
  assign rx_fall   = rx_prev_q & ~sync2_q;
  assign txd       = txd_q;
  assign unused_wr_bits = ^{pdata[31:23], pdata[19:17], pdata[15:8], PSTRB[3], PSTRB[1]};

  // A write landing on the launch edge wins, so a fresh TXSTART is never lost.
  always_comb begin
    txdata_d  = txdata_q;
    txstart_d = txstart_q;
    paren_d   = paren_q;
    parodd_d  = parodd_q;
    rxen_d    = rxen_q;
    if (tx_launch) txstart_d = 1'b0;
    if (wr_ctrl) begin
      if (PSTRB[0]) txdata_d = pdata[7:0];
      if (PSTRB[2]) begin
        txstart_d = pdata[16];
        paren_d   = pdata[20];
        parodd_d  = pdata[21];
        rxen_d    = pdata[22];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txdata_q  <= 8'h00;
      txstart_q <= 1'b0;
      paren_q   <= 1'b0;
      parodd_q  <= 1'b0;
      rxen_q    <= 1'b0;
    end else begin
      txdata_q  <= txdata_d;
      txstart_q <= txstart_d;
      paren_q   <= paren_d;
      parodd_q  <= parodd_d;
      rxen_q    <= rxen_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
      txd_q      <= 1'b1;
    end else if (tx_state_q == ST_IDLE) begin
      txd_q <= 1'b1;
      if (txstart_q) begin
        tx_state_q <= ST_START;
        tx_cnt_q   <= 4'd0;
        tx_sh_q    <= txdata_q;
        tx_par_q   <= (^txdata_q) ^ parodd_q;
        tx_paren_q <= paren_q;
        txd_q      <= 1'b0;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 4'd1;
      if (tx_cnt_q == 4'd15) begin
        case (tx_state_q)
          ST_START: begin
            tx_state_q <= ST_DATA;
            tx_bit_q   <= 3'd0;
            txd_q      <= tx_sh_q[0];
          end
          ST_DATA: begin
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= tx_paren_q ? ST_PARITY : ST_STOP;
              txd_q      <= tx_paren_q ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              txd_q    <= tx_sh_q[1];
            end
          end
          ST_PARITY: begin
            tx_state_q <= ST_STOP;
            txd_q      <= 1'b1;
          end
          default: begin
            tx_state_q <= ST_IDLE;
            txd_q      <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // START counts to the half-bit point; later states sample once per 16 clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= 4'd0;
      rx_bit_q    <= 3'd0;
      rx_sh_q     <= 8'h00;
      rx_paren_q  <= 1'b0;
      rx_parodd_q <= 1'b0;
      rx_parbit_q <= 1'b0;
      rxdata_q    <= 8'h00;
      rxvalid_q   <= 1'b0;
      parerr_q    <= 1'b0;
      frmerr_q    <= 1'b0;
    end else if (rx_state_q != ST_IDLE && !rxen_q) begin
      rx_state_q <= ST_IDLE;
    end else begin
      case (rx_state_q)
        ST_IDLE: begin
          rx_cnt_q <= 4'd0;
          if (rxen_q && rx_fall) begin
            rx_state_q  <= ST_START;
            rx_paren_q  <= paren_q;
            rx_parodd_q <= parodd_q;
          end
        end
        ST_START: begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_q <= 4'd0;
            if (sync2_q) begin
              rx_state_q <= ST_IDLE;
            end else begin
              rx_state_q <= ST_DATA;
              rx_bit_q   <= 3'd0;
              rxvalid_q  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_sh_q  <= {sync2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= rx_paren_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_parbit_q <= sync2_q;
            rx_state_q  <= ST_STOP;
          end
        end
        default: begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rxdata_q   <= rx_sh_q;
            rxvalid_q  <= 1'b1;
            parerr_q   <= rx_paren_q & ((^rx_sh_q) ^ rx_parodd_q ^ rx_parbit_q);
            frmerr_q   <= ~sync2_q;
            rx_state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    prdata = 32'h0;
    if (psel && !pwr) begin
      if (padd == 32'd0)
        prdata = {9'b0, rxen_q, parodd_q, paren_q, 3'b0, txstart_q, 8'b0, txdata_q};
      else if (padd == 32'd1)
        prdata = {20'b0, txbusy, frmerr_q, parerr_q, rxvalid_q, rxdata_q};
    end
  end

endmodule

// File: tb/tb_apb_uart.sv
// tb/tb_apb_uart.sv - directed bench for apb_uart: register vector table plus serial TX/RX sequences.
module tb_apb_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] padd = 32'h0;
  logic [31:0] pdata = 32'h0;
  logic        psel = 1'b0;
  logic        pen = 1'b0;
  logic        pwr = 1'b0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] prdata;
  logic        txd;
  logic        rxd = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic txd_log [300];
  logic busy_log [300];

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vq[$];

  apb_uart dut (
    .clk    (clk),
    .rst    (rst),
    .padd   (padd),
    .pdata  (pdata),
    .psel   (psel),
    .pen    (pen),
    .pwr    (pwr),
    .PSTRB  (pstrb),
    .prdata (prdata),
    .txd    (txd),
    .rxd    (rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    psel = 1'b1; pwr = 1'b1; pen = 1'b0; padd = a; pdata = d; pstrb = s;
    @(negedge clk);
    pen = 1'b1;
    @(negedge clk);
    psel = 1'b0; pen = 1'b0; pwr = 1'b0; pstrb = 4'h0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    psel = 1'b1; pwr = 1'b0; pen = 1'b0; padd = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic hold_rxd(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic parbit, input logic stopbit,
                            input logic with_par, input logic mid_check);
    logic [31:0] st;
    hold_rxd(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      hold_rxd(d[i], 16);
      if (mid_check && i == 0) begin
        peek(32'd1, st);
        check("rxvalid cleared after start", 32'(st[8]), 32'd0);
      end
    end
    if (with_par) hold_rxd(parbit, 16);
    hold_rxd(stopbit, 16);
    rxd = 1'b1;
  endtask

  task automatic record(input int n);
    psel = 1'b1; pwr = 1'b0; padd = 32'd1;
    for (int i = 0; i < n; i++) begin
      #1;
      txd_log[i]  = txd;
      busy_log[i] = prdata[11];
      @(negedge clk);
    end
    psel = 1'b0;
  endtask

  function automatic int first_low(input int n);
    for (int i = 0; i < n; i++) if (txd_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int busy_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (busy_log[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic add_vec(input int op, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e, input string nm);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.strb = s; v.exp = e; v.name = nm;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;
    logic [10:0] got_bits, exp_bits;
    logic        stop_lvl, g_ok;
    int          s, run;

    // op: 0 write, 1 read, 2 read with psel low, 3 psel with pwr high
    add_vec(0, 32'd0, 32'h0000_0000, 4'hF, 32'h0, "clr ctrl");
    add_vec(1, 32'd0, 32'h0,         4'h0, 32'h0000_0000, "ctrl after clear");
    add_vec(0, 32'd0, 32'hFFFE_FFFF, 4'hF, 32'h0, "set all ctrl");
    add_vec(1, 32'd0, 32'h0,         4'h0, 32'h0070_00FF, "ctrl all fields");
    add_vec(0, 32'd0, 32'h0000_0012, 4'h1, 32'h0, "byte0 only");
    add_vec(1, 32'd0, 32'h0,         4'h0, 32'h0070_0012, "ctrl byte0 strobe");
    add_vec(0, 32'd0, 32'h0000_0000, 4'h4, 32'h0, "byte2 clear");
    add_vec(1, 32'd0, 32'h0,         4'h0, 32'h0000_0012, "ctrl byte2 strobe");
    add_vec(0, 32'd0, 32'hFFFF_FF00, 4'hA, 32'h0, "bytes 1,3");
    add_vec(1, 32'd0, 32'h0,         4'h0, 32'h0000_0012, "ctrl unused bytes");
    add_vec(0, 32'd1, 32'hFFFF_FFFF, 4'hF, 32'h0, "write status");
    add_vec(1, 32'd1, 32'h0,         4'h0, 32'h0000_0000, "status ro");
    add_vec(1, 32'd2, 32'h0,         4'h0, 32'h0000_0000, "unmapped read");
    add_vec(2, 32'd0, 32'h0,         4'h0, 32'h0000_0000, "read psel low");
    add_vec(3, 32'd0, 32'h0,         4'h0, 32'h0000_0000, "read pwr high");

    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("reset txd", 32'(txd), 32'd1);
    peek(32'd0, rd); check("reset ctrl", rd, 32'h0);
    peek(32'd1, rd); check("reset status", rd, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset txd", 32'(txd), 32'd1);

    apb_write(32'd0, 32'h0051_0000, 4'b0100);
    record(250);
    s = first_low(250);
    check("strobe tx started", 32'(s >= 0), 32'd1);
    if (s < 0 || s > 120) s = 0;
    run = 0;
    for (int i = s; i < 250 && txd_log[i] === 1'b0; i++) run++;
    check("strobe low run", 32'(run), 32'd160);
    stop_lvl = txd_log[s + 160];
    check("strobe stop level", 32'(stop_lvl), 32'd1);
    check("strobe busy clks", 32'(busy_count(250)), 32'd176);
    peek(32'd0, rd); check("txstart self-clear", rd, 32'h0050_0000);

    foreach (vq[i]) begin
      case (vq[i].op)
        0: apb_write(vq[i].addr, vq[i].data, vq[i].strb);
        1: begin peek(vq[i].addr, rd); check(vq[i].name, rd, vq[i].exp); end
        2: begin padd = vq[i].addr; #1; check(vq[i].name, prdata, vq[i].exp); end
        default: begin
          psel = 1'b1; pwr = 1'b1; pen = 1'b0; padd = vq[i].addr; #1;
          check(vq[i].name, prdata, vq[i].exp);
          psel = 1'b0; pwr = 1'b0;
        end
      endcase
      @(negedge clk);
    end

    apb_write(32'd0, 32'h0011_00A5, 4'hF);
    record(250);
    s = first_low(250);
    check("tx a5 started", 32'(s >= 0), 32'd1);
    if (s < 0 || s > 120) s = 0;
    for (int k = 0; k < 11; k++) got_bits[k] = txd_log[s + 16 * k + 8];
    exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    check("tx a5 frame bits", 32'(got_bits), 32'(exp_bits));
    check("tx a5 busy clks", 32'(busy_count(250)), 32'd176);

    apb_write(32'd0, 32'h0050_0000, 4'b0100);
    hold_rxd(1'b1, 20);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
    hold_rxd(1'b1, 20);
    peek(32'd1, rd); check("rx good frame", rd, 32'h0000_010F);

    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1);
    hold_rxd(1'b1, 20);
    peek(32'd1, rd); check("rx error frame", rd, 32'h0000_070F);

    g_ok = 1'b1;
    rxd = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i == 4) rxd = 1'b1;
      peek(32'd1, rd);
      if (rd !== 32'h0000_070F || txd !== 1'b1) g_ok = 1'b0;
      @(negedge clk);
    end
    check("glitch no change", 32'(g_ok), 32'd1);
    peek(32'd1, rd); check("glitch status", rd, 32'h0000_070F);

    hold_rxd(1'b0, 40);
    apb_write(32'd0, 32'h0010_0000, 4'b0100);
    hold_rxd(1'b0, 160);
    hold_rxd(1'b1, 20);
    apb_write(32'd0, 32'h0050_0000, 4'b0100);
    hold_rxd(1'b1, 40);
    peek(32'd1, rd); check("rx abort status", rd, 32'h0000_060F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
